// File: rtl/act_fc_pkg.sv
// act_fc_pkg: shared types, default parameters and helpers for the
// multi-lane FC activation stage (act_fc / act_lane).
package act_fc_pkg;

    localparam int DEF_DATA_W     = 32;
    localparam int DEF_OUT_W      = 16;
    localparam int DEF_LANES      = 4;
    localparam int DEF_SHIFT_W    = 5;
    localparam int DEF_LEAK_SHIFT = 3;
    localparam int DEF_CNT_W      = 16;

    typedef enum logic [1:0] {
        ACT_PASS  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_CLIP  = 2'd3
    } act_mode_e;

    // Clamp v into the signed range of a w-bit word (w <= 63).
    // The caller truncates the result to w bits.
    function automatic logic signed [63:0] sat_signed(input logic signed [63:0] v,
                                                      input int w);
        logic signed [63:0] hi, lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -hi - 64'sd1;
        if (v > hi)      return hi;
        else if (v < lo) return lo;
        else             return v;
    endfunction

endpackage

// File: rtl/act_lane.sv
// act_lane: one lane of the activation datapath.
//   Stage 1 (comb before s1_x): activation of x under the beat's mode.
//   Stage 2 (comb before y):    round-half-up right shift, saturate to
//                               OUT_W, optional clamp to clip.
// Ports:
//   clk, rst_n          clock, async active-low reset
//   ld1, ld2            load enables for the stage-1 / output registers
//   x, mode             incoming lane word and its beat's mode
//   s1_mode/shift/clip  controls travelling with the beat held in stage 1
//   y                   registered OUT_W result
module act_lane
    import act_fc_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int SHIFT_W    = DEF_SHIFT_W,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     ld1,
    input  logic                     ld2,
    input  logic signed [DATA_W-1:0] x,
    input  act_mode_e                mode,
    input  act_mode_e                s1_mode,
    input  logic [SHIFT_W-1:0]       s1_shift,
    input  logic [OUT_W-1:0]         s1_clip,
    output logic [OUT_W-1:0]         y
);

    logic signed [DATA_W-1:0] act, s1_x;
    logic signed [DATA_W:0]   xe, rnd, sum, rq;
    logic signed [OUT_W:0]    rs, clip_s;

    always_comb begin
        act = x;
        case (mode)
            ACT_RELU, ACT_CLIP: if (x < 0) act = '0;
            ACT_LEAKY:          if (x < 0) act = x >>> LEAK_SHIFT;
            default: ;
        endcase
    end

    // One extra bit of headroom so adding the rounding half never wraps.
    always_comb begin
        xe  = (DATA_W+1)'(s1_x);
        rnd = '0;
        if (s1_shift != '0)
            rnd = (DATA_W+1)'(1) <<< (s1_shift - SHIFT_W'(1));
        sum    = xe + rnd;
        rq     = sum >>> s1_shift;
        rs     = (OUT_W+1)'(sat_signed(64'(rq), OUT_W));
        clip_s = $signed({1'b0, s1_clip});
        // rs is already <= OUT_W max, so min(rs, clip) covers all three bounds.
        if (s1_mode == ACT_CLIP && rs > clip_s)
            rs = clip_s;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_x <= '0;
            y    <= '0;
        end else begin
            if (ld1) s1_x <= act;
            if (ld2) y    <= rs[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/act_fc.sv
// act_fc: LANES-wide activation + requantise stage with a 2-deep
// valid/ready pipeline and a per-frame zero-lane counter.
// Ports:
//   clk, rst_n                    clock, async active-low reset
//   in_valid/in_ready/in_data/in_last   input beat handshake
//   mode, shift, clip             per-beat controls, sampled on accept
//   out_valid/out_ready/out_data/out_last output beat handshake
//   zero_cnt, zero_cnt_valid      zero lanes of the last completed frame
module act_fc
    import act_fc_pkg::*;
#(
    parameter int DATA_W     = DEF_DATA_W,
    parameter int OUT_W      = DEF_OUT_W,
    parameter int LANES      = DEF_LANES,
    parameter int SHIFT_W    = DEF_SHIFT_W,
    parameter int LEAK_SHIFT = DEF_LEAK_SHIFT,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [LANES*DATA_W-1:0] in_data,
    input  logic                    in_last,
    input  logic [1:0]              mode,
    input  logic [SHIFT_W-1:0]      shift,
    input  logic [OUT_W-1:0]        clip,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [LANES*OUT_W-1:0]  out_data,
    output logic                    out_last,
    output logic [CNT_W-1:0]        zero_cnt,
    output logic                    zero_cnt_valid
);

    localparam int STAGES = 2;

    typedef struct packed {
        act_mode_e          mode;
        logic [SHIFT_W-1:0] shift;
        logic [OUT_W-1:0]   clip;
        logic               last;
    } side_t;

    logic [STAGES:1]                vld_pipe;
    side_t                          s1_side;
    act_mode_e                      in_mode;
    logic                           s2_free, in_fire, ld2, out_fire;
    logic [LANES-1:0][DATA_W-1:0]   lane_in;
    logic [LANES-1:0][OUT_W-1:0]    lane_out;
    logic [CNT_W-1:0]               acc, acc_nxt;
    logic [CNT_W:0]                 nz, acc_sum;

    assign lane_in   = in_data;
    assign out_data  = lane_out;
    assign in_mode   = act_mode_e'(mode);
    assign out_valid = vld_pipe[2];

    // Output stage can take a beat if empty or draining this cycle.
    assign s2_free  = !vld_pipe[2] || out_ready;
    assign in_ready = rst_n && (!vld_pipe[1] || s2_free);
    assign in_fire  = in_valid && in_ready;
    assign ld2      = vld_pipe[1] && s2_free;
    assign out_fire = vld_pipe[2] && out_ready;

    for (genvar i = 0; i < LANES; i++) begin : g_lane
        act_lane #(
            .DATA_W    (DATA_W),
            .OUT_W     (OUT_W),
            .SHIFT_W   (SHIFT_W),
            .LEAK_SHIFT(LEAK_SHIFT)
        ) u_lane (
            .clk     (clk),
            .rst_n   (rst_n),
            .ld1     (in_fire),
            .ld2     (ld2),
            .x       (lane_in[i]),
            .mode    (in_mode),
            .s1_mode (s1_side.mode),
            .s1_shift(s1_side.shift),
            .s1_clip (s1_side.clip),
            .y       (lane_out[i])
        );
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_pipe <= '0;
            s1_side  <= '0;
            out_last <= 1'b0;
        end else begin
            if (in_ready) vld_pipe[1] <= in_valid;
            if (s2_free)  vld_pipe[2] <= vld_pipe[1];
            if (in_fire)  s1_side     <= '{mode: in_mode, shift: shift, clip: clip, last: in_last};
            if (ld2)      out_last    <= s1_side.last;
        end
    end

    // Zero lanes in the beat currently presented, then saturating add.
    always_comb begin
        nz = '0;
        for (int i = 0; i < LANES; i++)
            nz = nz + (CNT_W+1)'(lane_out[i] == '0);
        acc_sum = {1'b0, acc} + nz;
        acc_nxt = acc_sum[CNT_W] ? '1 : acc_sum[CNT_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc            <= '0;
            zero_cnt       <= '0;
            zero_cnt_valid <= 1'b0;
        end else begin
            zero_cnt_valid <= 1'b0;
            if (out_fire) begin
                if (out_last) begin
                    zero_cnt       <= acc_nxt;
                    zero_cnt_valid <= 1'b1;
                    acc            <= '0;
                end else begin
                    acc <= acc_nxt;
                end
            end
        end
    end

endmodule

// File: tb/tb_act_fc.sv
// tb_act_fc: randomized + directed bench for act_fc with a queue-based
// behavioural model and a single per-cycle compare process.
module tb_act_fc;

    localparam int DATA_W = 32;
    localparam int OUT_W  = 16;
    localparam int LANES  = 4;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic                    in_valid;
    logic                    in_ready;
    logic [LANES*DATA_W-1:0] in_data;
    logic                    in_last;
    logic [1:0]              mode;
    logic [4:0]              shift;
    logic [15:0]             clip;
    logic                    out_valid;
    logic                    out_ready = 1'b1;
    logic [LANES*OUT_W-1:0]  out_data;
    logic                    out_last;
    logic [15:0]             zero_cnt;
    logic                    zero_cnt_valid;

    act_fc dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .mode(mode), .shift(shift), .clip(clip),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
        .zero_cnt(zero_cnt), .zero_cnt_valid(zero_cnt_valid)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, got, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    function automatic logic [15:0] mdl_lane(input longint x, input int m, input int s, input int c);
        longint v = x;
        if ((m == 1 || m == 3) && v < 0) v = 0;
        if (m == 2 && v < 0) v = (v - 7) / 8;            // floor(v / 8)
        if (s > 0) v = v + (longint'(1) << (s - 1));
        if (v >= 0) v = v / (longint'(1) << s);
        else        v = -((-v + (longint'(1) << s) - 1) / (longint'(1) << s)); // floor
        if (v > 32767)  v = 32767;
        if (v < -32768) v = -32768;
        if (m == 3 && v > c) v = c;
        return 16'(v);
    endfunction

    function automatic logic [63:0] mdl(input logic [127:0] d, input int m, input int s, input int c);
        logic [63:0] r;
        for (int i = 0; i < LANES; i++)
            r[i*16 +: 16] = mdl_lane(longint'($signed(d[i*32 +: 32])), m, s, c);
        return r;
    endfunction

    function automatic logic [127:0] pk(input int a, input int b, input int c, input int d);
        return {32'(d), 32'(c), 32'(b), 32'(a)};
    endfunction

    function automatic logic [63:0] opk(input int a, input int b, input int c, input int d);
        return {16'(d), 16'(c), 16'(b), 16'(a)};
    endfunction

    typedef struct { logic [63:0] data; logic last; } exp_t;
    exp_t        q[$];
    exp_t        e;
    int          acc_m, exp_zc, zl;
    bit          pend, prev_stall, seen_stall;
    logic [65:0] prev_bus;

    always @(negedge clk) begin
        if (!rst_n) begin
            q.delete(); acc_m = 0; exp_zc = 0; pend = 0; prev_stall = 0;
        end else begin
            chk("zero_cnt_valid", zero_cnt_valid, pend);
            if (pend) chk("zero_cnt", zero_cnt, exp_zc);
            pend = 0;
            if (prev_stall) chk("stall_hold", {out_valid, out_last, out_data}, prev_bus);
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    chk("spurious_out", 1, 0);
                end else begin
                    e = q.pop_front();
                    chk("out_data", out_data, e.data);
                    chk("out_last", out_last, e.last);
                    zl = 0;
                    for (int i = 0; i < LANES; i++) if (e.data[i*16 +: 16] == 0) zl++;
                    acc_m = (acc_m + zl > 65535) ? 65535 : acc_m + zl;
                    if (e.last) begin exp_zc = acc_m; acc_m = 0; pend = 1; end
                end
            end
            prev_stall = out_valid && !out_ready;
            prev_bus   = {out_valid, out_last, out_data};
            if (in_valid && !in_ready) seen_stall = 1;
            if (in_valid && in_ready)
                q.push_back('{data: mdl(in_data, int'(mode), int'(shift), int'(clip)), last: in_last});
        end
    end

    // out_ready policy: 0 always high, 1 toggle, 2 random, 3 always low
    int or_mode = 0;
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: out_ready = 1'b1;
            1: out_ready = ~out_ready;
            2: out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
        endcase
    end

    // ---------------- stimulus helpers ----------------
    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [127:0] d, input int m, input int s, input int c, input logic l);
        in_valid = 1'b1; in_data = d; mode = 2'(m); shift = 5'(s); clip = 16'(c); in_last = l;
        for (int t = 0; ; t++) begin
            @(negedge clk);
            if (in_ready) break;
            if (t > 1000) begin chk("send_timeout", 1, 0); break; end
        end
        @(posedge clk); #1;
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic drain(input string nm);
        for (int t = 0; t < 500 && (q.size() != 0 || out_valid); t++) idle(1);
        chk({nm, "_drain"}, q.size(), 0);
        idle(2);
    endtask

    // Directed beat on an empty pipeline with out_ready high: checks the
    // 2-cycle latency and a hand-computed result.
    task automatic run_vec(input string nm, input logic [127:0] d, input int m, input int s,
                           input int c, input logic [63:0] expd);
        send(d, m, s, c, 1'b1);
        chk({nm, "_lat1"}, out_valid, 0);
        idle(1);
        chk({nm, "_lat2"}, out_valid, 1);
        chk(nm, out_data, expd);
        idle(2);
    endtask

    function automatic logic [31:0] rnd_word();
        case ($urandom_range(0, 3))
            0: return 32'($urandom_range(0, 600)) - 32'd300;
            1: return 32'($urandom_range(0, 140000)) - 32'd70000;
            2: return $urandom;
            default: return 32'd0;
        endcase
    endfunction

    function automatic logic [127:0] rnd_beat();
        return {rnd_word(), rnd_word(), rnd_word(), rnd_word()};
    endfunction

    task automatic wait_strobe(input string nm, input int expc);
        int t;
        for (t = 0; t < 50 && !zero_cnt_valid; t++) idle(1);
        chk({nm, "_strobe"}, zero_cnt_valid, 1);
        chk({nm, "_cnt"}, zero_cnt, 16'(expc));
        idle(1);
        chk({nm, "_one_cycle"}, zero_cnt_valid, 0);
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
        mode = '0; shift = '0; clip = '0; seen_stall = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("reset_state", {in_ready, out_valid, out_last, out_data, zero_cnt, zero_cnt_valid}, '0);
        rst_n = 1'b1;
        idle(2);

        // model pins
        chk("mdl_leaky", mdl_lane(-17, 2, 0, 0), 16'hFFFD);
        chk("mdl_round", mdl(pk(6, 5, 1, -9), 1, 2, 0), opk(2, 1, 0, 0));
        chk("mdl_neg_round", mdl_lane(-6, 0, 2, 0), 16'hFFFF);

        // directed vectors
        run_vec("relu",   pk(-5, 7, 0, 32767),            1, 0, 0,     opk(0, 7, 0, 32767));
        run_vec("pass",   pk(40000, -40000, -32768, 1),   0, 0, 0,     opk(32767, -32768, -32768, 1));
        run_vec("leaky",  pk(-17, -17, 8, -1),            2, 0, 0,     opk(-3, -3, 8, -1));
        run_vec("rshift", pk(6, 5, 1, -9),                1, 2, 0,     opk(2, 1, 0, 0));
        run_vec("clip",   pk(250, -4, 60, 100),           3, 0, 100,   opk(100, 0, 60, 100));
        run_vec("clip_hi",pk(50000, 3, 0, -1),            3, 0, 40000, opk(32767, 3, 0, 0));
        drain("directed");

        // zero count: 3-beat RELU frame with 5 negative lanes
        send(pk(-1, -2, 3, 4), 1, 0, 0, 1'b0);
        send(pk(-3, 5, 6, 7),  1, 0, 0, 1'b0);
        send(pk(-4, -5, 8, 9), 1, 0, 0, 1'b1);
        wait_strobe("zc_frame", 5);
        drain("zc");

        // backpressure: 8 back-to-back beats with out_ready toggling
        or_mode = 1; seen_stall = 0;
        for (int i = 0; i < 8; i++) send(rnd_beat(), $urandom_range(0, 3), $urandom_range(0, 8),
                                         $urandom_range(0, 65535), 1'(i == 7));
        chk("in_ready_fell", seen_stall, 1);
        drain("bp");
        or_mode = 0;

        // reset mid-frame with beats stuck in flight
        or_mode = 3;
        idle(1);
        send(pk(0, 0, -1, 2), 1, 0, 0, 1'b0);
        send(pk(0, 5, 0, 2),  1, 0, 0, 1'b0);
        idle(2);
        rst_n = 1'b0;
        idle(1);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_out_valid", out_valid, 0);
        rst_n = 1'b1;
        or_mode = 0;
        idle(5);
        chk("rst_no_strobe", zero_cnt_valid, 0);
        send(pk(-1, 2, 3, 4), 1, 0, 0, 1'b1);
        wait_strobe("after_rst", 1);
        drain("rst");

        // random stream
        or_mode = 2;
        for (int i = 0; i < 300; i++) begin
            send(rnd_beat(), $urandom_range(0, 3), $urandom_range(0, 31),
                 $urandom_range(0, 65535), 1'($urandom_range(0, 3) == 0));
            if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
        end
        or_mode = 0;
        drain("random");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/act_fc.md
# act_fc

Parametrised multi-lane activation stage for the fully-connected layer path. It sits between the FC accumulator output and the next layer's input buffer. Each beat carries LANES signed accumulator words. The block applies a selectable activation (pass, ReLU, leaky ReLU, clipped ReLU), requantises to OUT_W with round-half-up and saturation, and reports a per-frame zero count for sparsity monitoring. Beats move through a 2-stage valid/ready pipeline with full backpressure.

## Interface
- DATA_W, 32, signed input word width per lane
- OUT_W, 16, signed output word width per lane
- LANES, 4, parallel lanes per beat
- SHIFT_W, 5, width of requantisation shift control
- LEAK_SHIFT, 3, leaky-ReLU negative slope 2^-LEAK_SHIFT
- CNT_W, 16, zero-count width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset; one clock, asynchronous active-low reset
- in_valid  in  1  input beat valid
- in_ready  out  1  block can accept a beat
- in_data  in  LANES*DATA_W  lane i at bits [i*DATA_W +: DATA_W]
- in_last  in  1  final beat of frame
- mode  in  2  0 PASS, 1 RELU, 2 LEAKY, 3 CLIP
- shift  in  SHIFT_W  requantisation right-shift
- clip  in  OUT_W  unsigned upper bound for CLIP mode
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*OUT_W  lane i at bits [i*OUT_W +: OUT_W]
- out_last  out  1  frame end, aligned with out_data
- zero_cnt  out  CNT_W  zero output lanes in last completed frame
- zero_cnt_valid  out  1  one-cycle strobe, zero_cnt updated

## Operation
- mode, shift and clip are sampled with each beat at the input handshake and travel with it. Changing them mid-stream affects only later beats.
- Stage 1 applies the activation per lane, with x signed DATA_W:
  - PASS: x.
  - RELU: x<0 gives 0.
  - LEAKY: x<0 gives x>>>LEAK_SHIFT (arithmetic, floor).
  - CLIP: x<0 gives 0.
- Stage 2 requantises each lane:
  - r = (x + (shift>0 ? 2^(shift-1) : 0)) >>> shift, computed in DATA_W+1 bits so there is no overflow.
  - r is saturated to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - In CLIP mode, r is then clamped to min(r, clip, 2^(OUT_W-1)-1).
- Zero counter:
  - Each output handshake adds the number of lanes whose out_data equals 0.
  - The accumulator saturates at 2^CNT_W-1.
  - On a handshake with out_last=1, the total including that beat is loaded into zero_cnt. The cycle after that handshake, zero_cnt_valid is 1 and the accumulator is cleared.
  - A frame of exactly one beat is legal.

## Timing
- Reset values:
  - out_valid=0, out_data=0, out_last=0.
  - zero_cnt=0, zero_cnt_valid=0, accumulator=0, both stage valids=0.
  - in_ready is forced 0 while rst_n=0.
- Latency: with out_ready held 1, out_valid rises 2 cycles after the input handshake. Throughput is 1 beat/cycle.
- A stage advances when its successor is empty or is being consumed in the same cycle.
- in_ready = !s1_valid | s1_advance. This is combinational from registers and out_ready; there is no combinational path from in_valid.
- While out_valid=1 and out_ready=0, out_data and out_last hold stable. No beat is dropped or duplicated.
- A simultaneous input accept and output drain on a full pipeline sustains full rate.
- Reset asserted mid-frame discards all in-flight beats and the partial zero count. No zero_cnt_valid pulse is issued for the aborted frame.

## Structure
- act_fc_pkg holds:
  - the mode enum act_mode_e (ACT_PASS, ACT_RELU, ACT_LEAKY, ACT_CLIP);
  - a sat_signed function (width-generic saturation);
  - the default parameter constants.
- Sub-module act_lane holds one lane's activation and requantise datapath, split at the stage boundary. It is instantiated LANES times by generate.
- act_fc owns the pipeline valids, the handshake and the zero counter.

## Test plan
- RELU, shift 0, lanes {-5, 7, 0, 32767} -> out_data {0, 7, 0, 32767} two cycles after accept.
- PASS, shift 0, lanes {40000, -40000, -32768, 1} -> {32767, -32768, -32768, 1}.
- Leaky and rounding:
  - LEAKY, shift 0, -17 -> -3.
  - RELU, shift 2, lanes {6, 5, 1, -9} -> {2, 1, 0, 0}.
- CLIP, clip=100, shift 0, lanes {250, -4, 60, 100} -> {100, 0, 60, 100}. With clip=40000 (above the OUT_W maximum), 50000 -> 32767.
- Backpressure: 8-beat random stream with out_ready toggling 1,0,1,0… -> output sequence identical to input order; out_data stable through stalls; in_ready falls once both stages are full.
- Zero count:
  - A 3-beat RELU frame with 5 negative lanes total, last on beat 3 -> zero_cnt=5 with a one-cycle zero_cnt_valid.
  - rst_n pulsed mid-frame -> no strobe, and the next frame counts from 0.
